rx_word_aligner: RTL and testbench

- Sits directly downstream of the 2:1 gearbox in the CMOS LVDS receive path, in the clk_rxg_x1 domain.
- Consumes the gearbox's 12-bit words, which may carry an arbitrary 0..11-bit misalignment, including a half-word phase slip.
- Finds the bit offset using the sensor training word and presents aligned 12-bit pixel words with lock status to the pixel unpacker.

---
 rtl/rx_word_aligner.sv | 152 +++++++++++++++
 tb/tb_rx_word_aligner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_word_aligner.sv
// Word aligner for the CMOS LVDS receive path: finds the bit offset of the
// training word in the gearbox stream and presents realigned 12-bit words.
module rx_word_aligner #(
   parameter int              DW         = 12,
   parameter logic [DW-1:0]   TRAIN_WORD = 12'h0F3,
   parameter int              SETTLE     = 2,
   parameter int              LOCK_CNT   = 16,
   parameter int              UNLOCK_CNT = 4
) (
   input  logic          clk_rxg_x1,
   input  logic          align_reset,
   input  logic          train_en,
   input  logic [DW-1:0] data_in,
   output logic [DW-1:0] data_out,
   output logic          data_valid,
   output logic          locked,
   output logic [3:0]    offset,
   output logic          align_err
);

   localparam int SW = $clog2(SETTLE + 1);
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int XW = $clog2(UNLOCK_CNT + 1);

   typedef enum logic [1:0] {IDLE, SEARCH, CHECK, LOCKED} state_t;

   state_t          state_q, state_d;
   logic [3:0]      offset_q, offset_d, offset_nxt;
   logic [SW-1:0]   settle_q, settle_d;
   logic [MW-1:0]   match_q, match_d;
   logic [XW-1:0]   miss_q, miss_d;
   logic [3:0]      sweep_q, sweep_d;
   logic            err_d;
   logic [DW-1:0]   data_d;
   logic [2*DW-1:0] win, win_sh;
   logic [DW-1:0]   aligned;
   logic            match;

   // Shifting the window left by offset puts win[23-offset:12-offset] on top.
   assign win        = {data_d, data_in};
   assign win_sh     = win << offset_q;
   assign aligned    = win_sh[2*DW-1:DW];
   assign match      = (aligned == TRAIN_WORD);
   assign offset_nxt = (offset_q == 4'(DW - 1)) ? '0 : offset_q + 4'd1;

   assign locked = (state_q == LOCKED);
   assign offset = offset_q;

   always_ff @(posedge clk_rxg_x1 or posedge align_reset) begin
      if (align_reset) begin
         state_q    <= IDLE;
         offset_q   <= '0;
         settle_q   <= '0;
         match_q    <= '0;
         miss_q     <= '0;
         sweep_q    <= '0;
         align_err  <= 1'b0;
         data_d     <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         state_q    <= state_d;
         offset_q   <= offset_d;
         settle_q   <= settle_d;
         match_q    <= match_d;
         miss_q     <= miss_d;
         sweep_q    <= sweep_d;
         align_err  <= err_d;
         data_d     <= data_in;
         data_out   <= aligned;
         data_valid <= locked & ~train_en;
      end
   end

   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      settle_d = settle_q;
      match_d  = match_q;
      miss_d   = miss_q;
      sweep_d  = sweep_q;
      err_d    = align_err;
      case (state_q)
         IDLE: begin
            if (train_en) begin
               state_d  = SEARCH;
               settle_d = '0;
            end
         end
         SEARCH: begin
            if (!train_en) begin
               state_d  = IDLE;
               settle_d = '0;
               match_d  = '0;
               miss_d   = '0;
               sweep_d  = '0;
            end else if (settle_q != SW'(SETTLE)) begin
               settle_d = settle_q + SW'(1);
            end else if (match) begin
               state_d  = CHECK;
               settle_d = '0;
               match_d  = MW'(1);
            end else begin
               offset_d = offset_nxt;
               settle_d = '0;
               // Twelfth consecutive failed offset completes a full sweep.
               if (sweep_q == 4'(DW - 1)) begin
                  err_d   = 1'b1;
                  sweep_d = '0;
               end else begin
                  sweep_d = sweep_q + 4'd1;
               end
            end
         end
         CHECK: begin
            if (!train_en) begin
               state_d  = IDLE;
               settle_d = '0;
               match_d  = '0;
               miss_d   = '0;
               sweep_d  = '0;
            end else if (!match) begin
               state_d  = SEARCH;
               offset_d = offset_nxt;
               settle_d = '0;
               match_d  = '0;
            end else if (match_q == MW'(LOCK_CNT - 1)) begin
               state_d = LOCKED;
               match_d = '0;
               sweep_d = '0;
               err_d   = 1'b0;
            end else begin
               match_d = match_q + MW'(1);
            end
         end
         LOCKED: begin
            if (!train_en || match) begin
               miss_d = '0;
            end else if (miss_q == XW'(UNLOCK_CNT - 1)) begin
               state_d  = SEARCH;
               offset_d = offset_nxt;
               settle_d = '0;
               miss_d   = '0;
            end else begin
               miss_d = miss_q + XW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rx_word_aligner.sv
// Bench for rx_word_aligner: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the alignment rules.
module tb_rx_word_aligner;

   localparam logic [11:0] TW = 12'h0F3;

   logic        clk_rxg_x1 = 1'b0;
   logic        align_reset;
   logic        train_en;
   logic [11:0] data_in;
   logic [11:0] data_out;
   logic        data_valid;
   logic        locked;
   logic [3:0]  offset;
   logic        align_err;

   int n_chk  = 0;
   int n_fail = 0;

   // model state
   int m_dd, m_out, m_valid, m_lock, m_off, m_err;
   int m_mode;          // 0 idle, 1 hunting, 2 confirming, 3 locked
   int m_wait, m_good, m_bad, m_tried;

   rx_word_aligner #(
      .DW(12), .TRAIN_WORD(TW), .SETTLE(2), .LOCK_CNT(16), .UNLOCK_CNT(4)
   ) dut (
      .clk_rxg_x1 (clk_rxg_x1),
      .align_reset(align_reset),
      .train_en   (train_en),
      .data_in    (data_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .locked     (locked),
      .offset     (offset),
      .align_err  (align_err)
   );

   always #5 clk_rxg_x1 = ~clk_rxg_x1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] rotr(input logic [11:0] v, input int k);
      logic [23:0] t;
      t = {v, v};
      return t[k +: 12];
   endfunction

   task automatic model_reset();
      m_dd = 0; m_out = 0; m_valid = 0; m_lock = 0; m_off = 0; m_err = 0;
      m_mode = 0; m_wait = 0; m_good = 0; m_bad = 0; m_tried = 0;
   endtask

   task automatic model_abandon();
      m_mode = 0; m_wait = 0; m_good = 0; m_bad = 0; m_tried = 0;
   endtask

   task automatic model_step(input int te, input int din);
      int a;
      bit hit;
      a   = ((m_dd << m_off) | (din >> (12 - m_off))) & 'hFFF;
      hit = (a == TW);
      m_out   = a;
      m_valid = (m_lock != 0 && te == 0) ? 1 : 0;
      if (m_mode == 0) begin
         if (te != 0) begin m_mode = 1; m_wait = 0; end
      end else if (m_mode == 1) begin
         if (te == 0) model_abandon();
         else if (m_wait < 2) m_wait++;
         else if (hit) begin m_mode = 2; m_good = 1; m_wait = 0; end
         else begin
            m_off = (m_off + 1) % 12;
            m_wait = 0;
            m_tried++;
            if (m_tried == 12) begin m_err = 1; m_tried = 0; end
         end
      end else if (m_mode == 2) begin
         if (te == 0) model_abandon();
         else if (!hit) begin m_mode = 1; m_off = (m_off + 1) % 12; m_wait = 0; m_good = 0; end
         else begin
            m_good++;
            if (m_good == 16) begin m_mode = 3; m_good = 0; m_tried = 0; m_err = 0; end
         end
      end else begin
         if (te == 0 || hit) m_bad = 0;
         else begin
            m_bad++;
            if (m_bad == 4) begin m_mode = 1; m_off = (m_off + 1) % 12; m_bad = 0; m_wait = 0; end
         end
      end
      m_lock = (m_mode == 3) ? 1 : 0;
      m_dd   = din;
   endtask

   task automatic compare_all();
      check_val("data_out",   data_out,   m_out);
      check_val("data_valid", data_valid, m_valid);
      check_val("locked",     locked,     m_lock);
      check_val("offset",     offset,     m_off);
      check_val("align_err",  align_err,  m_err);
   endtask

   task automatic cyc(input logic te, input logic [11:0] d);
      train_en = te;
      data_in  = d;
      @(posedge clk_rxg_x1);
      model_step(int'(te), int'(d));
      #1;
      compare_all();
   endtask

   task automatic reset_dut();
      train_en    = 1'b0;
      data_in     = '0;
      align_reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(posedge clk_rxg_x1);
      #1;
      align_reset = 1'b0;
   endtask

   task automatic run_to_lock(input logic [11:0] d, input string tag);
      int n;
      n = 0;
      while (m_lock == 0 && n < 80) begin
         cyc(1'b1, d);
         n++;
      end
      check_val(tag, locked, 1);
   endtask

   logic [11:0] skew5;
   logic [11:0] w;

   initial begin
      align_reset = 1'b0;
      train_en    = 1'b0;
      data_in     = '0;
      skew5       = rotr(TW, 5);
      #2;

      // aligned stream: lock exactly 19 cycles after train_en rises
      reset_dut();
      for (int i = 0; i < 18; i++) cyc(1'b1, TW);
      check_val("pre_lock", locked, 0);
      cyc(1'b1, TW);
      check_val("lock_time", locked, 1);
      check_val("lock_off0", offset, 0);

      // pixel data while locked
      for (int i = 0; i < 40; i++) cyc(1'b0, 12'($urandom));
      check_val("pix_valid", data_valid, 1);
      check_val("pix_lock",  locked, 1);

      // 5-bit skew
      reset_dut();
      run_to_lock(skew5, "skew_lock");
      check_val("skew_off", offset, 5);
      check_val("skew_err", align_err, 0);

      // short burst of bad words keeps lock, longer burst drops it
      for (int i = 0; i < 4; i++) cyc(1'b1, skew5);
      for (int i = 0; i < 2; i++) cyc(1'b1, 12'h000);
      for (int i = 0; i < 6; i++) cyc(1'b1, skew5);
      check_val("miss3_lock", locked, 1);
      for (int i = 0; i < 4; i++) cyc(1'b1, 12'h000);
      check_val("miss4_unlock", locked, 0);
      check_val("miss4_off", offset, 6);
      for (int i = 0; i < 10; i++) cyc(1'b1, skew5);
      cyc(1'b0, skew5);

      // all-zero stream: full sweep after 36 search cycles
      reset_dut();
      for (int i = 0; i < 36; i++) cyc(1'b1, 12'h000);
      check_val("sweep_pre", align_err, 0);
      cyc(1'b1, 12'h000);
      check_val("sweep_err", align_err, 1);
      check_val("sweep_wrap", offset, 0);
      for (int i = 0; i < 20; i++) cyc(1'b1, 12'h000);
      check_val("sweep_nolock", locked, 0);

      // async reset in the middle of the confirmation run
      reset_dut();
      for (int i = 0; i < 26; i++) cyc(1'b1, skew5);
      check_val("mid_off", offset, 5);
      #3;
      align_reset = 1'b1;
      #1;
      check_val("rst_lock", locked, 0);
      check_val("rst_off",  offset, 0);
      check_val("rst_data", data_out, 0);
      check_val("rst_err",  align_err, 0);
      model_reset();
      @(posedge clk_rxg_x1);
      #1;
      align_reset = 1'b0;
      run_to_lock(skew5, "relock");
      check_val("relock_off", offset, 5);

      // randomized segments: training at random skew with corruption, then pixels
      for (int s = 0; s < 6; s++) begin
         int k;
         k = int'($urandom_range(0, 11));
         w = rotr(TW, k);
         for (int i = 0; i < 70; i++)
            cyc(1'b1, ($urandom_range(0, 15) == 0) ? 12'($urandom) : w);
         for (int i = 0; i < 25; i++) cyc(1'b0, 12'($urandom));
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
